// File: rtl/led_pattern_sched.sv
// Round-robin arbiter and step sequencer for the two user LEDs.
// Two requesters each offer a multi-step 2-bit pattern. The winner's pattern is
// latched and played one step per TICK_DIV cycles. A dark gap of TICK_DIV
// cycles follows each pattern before the next grant can be made.
module led_pattern_sched #(
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter int unsigned STEPS    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_a,
  input  logic [2*STEPS-1:0] pat_a,
  input  logic               req_b,
  input  logic [2*STEPS-1:0] pat_b,
  output logic               grant_a,
  output logic               grant_b,
  output logic               done,
  output logic               busy,
  output logic               led0,
  output logic               led1
);

  localparam int unsigned TickW = $clog2(TICK_DIV);
  localparam int unsigned StepW = $clog2(STEPS);
  localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);
  localparam logic [StepW-1:0] StepMax = StepW'(STEPS - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [TickW-1:0]   tick_q, tick_d;
  logic [StepW-1:0]   step_q, step_d;
  logic [StepW-1:0]   step_nxt;
  logic [2*STEPS-1:0] pat_q, pat_d;
  logic               last_b_q, last_b_d;  // 1: B was granted most recently
  logic               grant_a_q, grant_a_d;
  logic               grant_b_q, grant_b_d;
  logic               done_q, done_d;
  logic [1:0]         led_q, led_d;        // {led1, led0}
  logic               pick_a, pick_b;

  // Ties go to whichever requester was not granted last.
  assign pick_a   = req_a & (~req_b | last_b_q);
  assign pick_b   = req_b & (~req_a | ~last_b_q);
  assign step_nxt = step_q + 1'b1;

  // Next-state logic: arbitration in IDLE, step sequencing in RUN, dark gap in GAP.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    step_d    = step_q;
    pat_d     = pat_q;
    last_b_d  = last_b_q;
    grant_a_d = 1'b0;
    grant_b_d = 1'b0;
    done_d    = 1'b0;
    led_d     = 2'b00;
    case (state_q)
      StIdle: begin
        if (pick_a) begin
          grant_a_d = 1'b1;
          pat_d     = pat_a;
          last_b_d  = 1'b0;
          led_d     = pat_a[1:0];
          tick_d    = '0;
          step_d    = '0;
          state_d   = StRun;
        end else if (pick_b) begin
          grant_b_d = 1'b1;
          pat_d     = pat_b;
          last_b_d  = 1'b1;
          led_d     = pat_b[1:0];
          tick_d    = '0;
          step_d    = '0;
          state_d   = StRun;
        end
      end
      StRun: begin
        if (tick_q == TickMax) begin
          tick_d = '0;
          if (step_q == StepMax) begin
            done_d  = 1'b1;
            state_d = StGap;
          end else begin
            step_d = step_nxt;
            led_d  = pat_q[{step_nxt, 1'b0} +: 2];
          end
        end else begin
          tick_d = tick_q + 1'b1;
          led_d  = pat_q[{step_q, 1'b0} +: 2];
        end
      end
      StGap: begin
        if (tick_q == TickMax) begin
          tick_d  = '0;
          state_d = StIdle;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; reset wins over everything, mid-pattern included.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      tick_q    <= '0;
      step_q    <= '0;
      pat_q     <= '0;
      last_b_q  <= 1'b1;
      grant_a_q <= 1'b0;
      grant_b_q <= 1'b0;
      done_q    <= 1'b0;
      led_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      step_q    <= step_d;
      pat_q     <= pat_d;
      last_b_q  <= last_b_d;
      grant_a_q <= grant_a_d;
      grant_b_q <= grant_b_d;
      done_q    <= done_d;
      led_q     <= led_d;
    end
  end

  assign grant_a = grant_a_q;
  assign grant_b = grant_b_q;
  assign done    = done_q;
  assign busy    = (state_q != StIdle);
  assign led0    = led_q[0];
  assign led1    = led_q[1];

endmodule

// File: tb/tb_led_pattern_sched.sv
// Bench for led_pattern_sched: a timeline model (grant cycle + offset arithmetic)
// is compared against the DUT every cycle, plus hand-computed literal checks.
module tb_led_pattern_sched;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned STEPS    = 4;
  localparam int RunLen  = STEPS * TICK_DIV;        // 16
  localparam int SlotLen = (STEPS + 1) * TICK_DIV;  // 20

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, req_b;
  logic [7:0] pat_a, pat_b;
  logic       grant_a, grant_b, done, busy, led0, led1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  led_pattern_sched #(
    .TICK_DIV(TICK_DIV),
    .STEPS   (STEPS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req_a  (req_a),
    .pat_a  (pat_a),
    .req_b  (req_b),
    .pat_b  (pat_b),
    .grant_a(grant_a),
    .grant_b(grant_b),
    .done   (done),
    .busy   (busy),
    .led0   (led0),
    .led1   (led1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a pattern is a timeline anchored at its grant cycle m_t0.
  bit         m_active = 1'b0;
  int         m_t0     = 0;
  logic [7:0] m_pat    = '0;
  bit         m_last_b = 1'b1;
  bit         m_won_a  = 1'b0;
  bit         m_won_b  = 1'b0;
  logic [5:0] e_vec    = '0;  // {grant_a, grant_b, done, busy, led1, led0}

  // Advance the model on each edge and derive expectations for the new cycle.
  always @(posedge clk) begin
    int d;
    logic [1:0] e_led;
    if (rst) begin
      m_active = 1'b0;
      m_last_b = 1'b1;
    end else if (!m_active || (cyc - m_t0) >= SlotLen) begin
      m_active = 1'b0;
      m_won_a  = 1'b0;
      m_won_b  = 1'b0;
      if (req_a && (!req_b || m_last_b)) begin
        m_won_a = 1'b1; m_pat = pat_a; m_last_b = 1'b0;
      end else if (req_b) begin
        m_won_b = 1'b1; m_pat = pat_b; m_last_b = 1'b1;
      end
      if (m_won_a || m_won_b) begin
        m_active = 1'b1;
        m_t0     = cyc + 1;
      end
    end
    cyc = cyc + 1;
    d = cyc - m_t0;
    if (!m_active) begin
      e_vec = '0;
    end else begin
      e_led = (d < RunLen) ? m_pat[2*(d/TICK_DIV) +: 2] : 2'b00;
      e_vec = {(d == 0) && m_won_a, (d == 0) && m_won_b, d == RunLen, d < SlotLen, e_led};
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cyc > 0)
      check("cycle_outputs", {26'd0, grant_a, grant_b, done, busy, led1, led0}, {26'd0, e_vec});
  end

  task automatic wait_grant(output int c, output logic ga, output logic gb);
    int n;
    c = -1; ga = 1'b0; gb = 1'b0; n = 0;
    while (n < 60) begin
      @(negedge clk);
      if (grant_a || grant_b) begin
        c = cyc; ga = grant_a; gb = grant_b; n = 60;
      end else begin
        n++;
      end
    end
    if (c < 0) begin
      checks++; errors++;
      $display("FAIL grant_timeout: got none expected grant within 60 cycles");
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got busy=%b expected 0 within 60 cycles", busy);
    end
  endtask

  initial begin
    int         g [4];
    logic       ga, gb;
    int         t, r;
    logic [1:0] led_exp2 [4];
    led_exp2 = '{2'b00, 2'b11, 2'b01, 2'b10};

    // 1. Reset held three cycles with both requests high.
    rst = 1'b1; req_a = 1'b1; req_b = 1'b1; pat_a = 8'h1B; pat_b = 8'hE4;
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", {26'd0, grant_a, grant_b, done, busy, led1, led0}, 32'd0);
    end
    rst = 1'b0;

    // 3. Tie held continuously: A, B, A, B, each 21 cycles apart.
    for (int i = 0; i < 4; i++) begin
      wait_grant(g[i], ga, gb);
      check("tie_order_a", {31'd0, ga}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("tie_order_b", {31'd0, gb}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i > 0) check("tie_spacing", g[i] - g[i-1], 32'd21);
    end
    req_a = 1'b0; req_b = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    // 2. Single A with a hand-decoded pattern.
    req_a = 1'b1; pat_a = 8'b10_01_11_00; r = cyc;
    wait_grant(t, ga, gb);
    check("single_a_latency", t - r, 32'd1);
    check("single_a_grant", {30'd0, ga, gb}, 32'd2);
    for (int d = 0; d <= 20; d++) begin
      if (d > 0) @(negedge clk);
      if (d == 0) req_a = 1'b0;
      check("single_a_led", {30'd0, led1, led0}, (d < 16) ? {30'd0, led_exp2[d/4]} : 32'd0);
      check("single_a_done", {31'd0, done}, (d == 16) ? 32'd1 : 32'd0);
      check("single_a_busy", {31'd0, busy}, (d < 20) ? 32'd1 : 32'd0);
    end

    // 4. Lone B is granted back-to-back; A never.
    req_b = 1'b1; pat_b = 8'b01_10_01_10;
    for (int i = 0; i < 3; i++) begin
      wait_grant(g[i], ga, gb);
      check("lone_b_grant", {30'd0, ga, gb}, 32'd1);
      if (i > 0) check("lone_b_spacing", g[i] - g[i-1], 32'd21);
    end
    req_b = 1'b0;
    wait_idle();
    @(negedge clk);

    // 5. Pattern changes after the grant do not reach the LEDs.
    req_a = 1'b1; pat_a = 8'hFF;
    wait_grant(t, ga, gb);
    req_a = 1'b0;
    for (int d = 0; d < 16; d++) begin
      if (d > 0) @(negedge clk);
      if (d == 2) pat_a = 8'h00;
      check("isolation_led", {30'd0, led1, led0}, 32'd3);
    end
    wait_idle();
    @(negedge clk);

    // 6. Reset mid-run: LEDs dark, no done, and A wins the next tie.
    req_a = 1'b1; pat_a = 8'b11_10_01_11;
    wait_grant(t, ga, gb);
    req_a = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1; req_a = 1'b1; req_b = 1'b1;
    @(negedge clk);
    check("midrst_outputs", {26'd0, grant_a, grant_b, done, busy, led1, led0}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_tie_a", {30'd0, grant_a, grant_b}, 32'd2);
    req_a = 1'b0; req_b = 1'b0;
    for (int d = 0; d < 10; d++) begin
      @(negedge clk);
      check("midrst_no_done", {31'd0, done}, 32'd0);
    end
    wait_idle();
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
